bsg_arb_rr_mux_p32_els_p5: RTL and testbench
============================================

BSG_ARB_RR_MUX_P32_ELS_P5 -- requirements
Module: bsg_arb_rr_mux_p32_els_p5

Interface
REQ-001 SHALL have parameter width_p, default 32: data width per requester.
REQ-002 SHALL have parameter els_p, default 5: number of requesters.
REQ-003 SHALL have parameter id_width_p, default 3: source-id width, equal to clog2(els_p).
REQ-004 SHALL have port clk_i, input, 1: single clock; all state rising-edge.
REQ-005 SHALL have port reset_n_i, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port v_i, input, els_p: per-requester valid.
REQ-007 SHALL have port data_i, input, els_p*width_p: requester k occupies bits [k*width_p +: width_p].
REQ-008 SHALL have port en_mask_i, input, els_p: 1 = requester eligible, 0 = excluded from arbitration.
REQ-009 SHALL have port ready_o, output, els_p: one-hot-or-zero accept to requesters.
REQ-010 SHALL have port v_o, output, 1: output register holds valid data.
REQ-011 SHALL have port data_o, output, width_p: selected data, registered.
REQ-012 SHALL have port id_o, output, id_width_p: index of the source of data_o.
REQ-013 SHALL have port ready_i, input, 1: consumer accepts data_o when v_o & ready_i.

Function
REQ-014 SHALL compute load_en = ~v_o | ready_i each cycle; output slot reloadable only when load_en=1.
REQ-015 SHALL form the eligible vector req = v_i & en_mask_i.
REQ-016 SHALL drive ready_o as the round-robin one-hot pick of req when load_en=1, otherwise all zeros; ready_o SHALL never have more than one bit set.
REQ-017 SHALL scan priority from pointer index p upward with wrap (els_p-1 -> 0); the first set bit of req wins.
REQ-018 SHALL accept requester k when v_i[k] & ready_o[k]; on the next edge, data_o <= data_i[k], id_o <= k, v_o <= 1.
REQ-019 SHALL have accept-to-v_o latency of exactly 1 cycle.
REQ-020 SHALL update p to (k+1) mod els_p on an accept by k; p SHALL remain unchanged in cycles with no accept.
REQ-021 SHALL, when v_o=1, ready_i=1 and no requester is accepted, clear v_o to 0 on the next edge while data_o and id_o hold their values.
REQ-022 SHALL, when v_o=1 and ready_i=0, hold v_o, data_o and id_o stable, drive ready_o=0 and hold p.
REQ-023 SHALL support simultaneous drain and load: v_o=1, ready_i=1 and an accept in the same cycle reloads with zero bubble.
REQ-024 SHALL ignore ready_i when v_o=0.
REQ-025 SHALL grant each continuously eligible requester within els_p consecutive accepts (starvation bound).
REQ-026 SHALL treat requesters with en_mask_i=0 as not requesting, without altering p; a mask change takes effect in the same cycle.
REQ-027 SHALL place no requirement on data_i[k] unless v_i[k]=1; a requester holds v_i and data_i until accepted.

Reset
REQ-028 SHALL, while reset_n_i=0, force v_o=0, data_o=0, id_o=0 and p=0 asynchronously; ready_o SHALL be 0 during reset.
REQ-029 SHALL discard any in-flight output on reset; after deassertion, requester 0 has highest priority.
REQ-030 SHALL synchronize reset deassertion externally; the block uses reset_n_i directly.

Structure
REQ-031 SHALL take width_p, els_p and id_width_p defaults from a shared package, along with the clog2 helper.
REQ-032 SHALL implement the round-robin picker (req, p -> one-hot grant plus encoded index) as sub-module bsg_rr_pick_one_hot.
REQ-033 SHALL realise data selection as a one-hot AND-OR mux of data_i under ready_o, per-bit OR of masked words, feeding the output register.

Verification
REQ-034 SHALL be covered by: after reset, v_i=5'b11111, mask all 1, ready_i=1 held -> id_o sequence 0,1,2,3,4,0 on consecutive cycles, v_o=1 each cycle.
REQ-035 SHALL be covered by: v_i=5'b10100, ready_i=0 after the first load -> id_o=2 held, ready_o=0; then ready_i=1 -> next id_o=4, then 2.
REQ-036 SHALL be covered by: v_i=5'b00001 for one accept with data 0xDEADBEEF, then v_i=0 with ready_i=1 -> data_o=0xDEADBEEF for 1 cycle, then v_o=0 with data_o held.
REQ-037 SHALL be covered by: v_i=5'b11111, en_mask_i=5'b01010 -> only ids 1 and 3 alternate; ready_o[0,2,4] stay 0.
REQ-038 SHALL be covered by: reset_n_i pulsed low mid-stream with v_o=1, id_o=3 -> v_o, data_o, id_o go 0 immediately; the first grant after release goes to the lowest set index.
REQ-039 SHALL be covered by: random v_i, mask and ready_i over 10k cycles -> ready_o one-hot-or-zero, no data loss or duplication versus a scoreboard, starvation bound holds.

Source files
------------

// File: rtl/bsg_arb_rr_mux_p32_els_p5_pkg.sv
// bsg_arb_rr_mux_p32_els_p5_pkg: shared defaults and the clog2 helper for the round-robin mux
package bsg_arb_rr_mux_p32_els_p5_pkg;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   localparam int WIDTH_P    = 32;
   localparam int ELS_P      = 5;
   localparam int ID_WIDTH_P = clog2(ELS_P);

endpackage

// File: rtl/bsg_rr_pick_one_hot.sv
// bsg_rr_pick_one_hot: first set request scanning upward from ptr with wrap, as one-hot plus index
module bsg_rr_pick_one_hot
   import bsg_arb_rr_mux_p32_els_p5_pkg::*;
#(
   parameter int els_p      = ELS_P,
   parameter int id_width_p = ID_WIDTH_P
) (
   input  logic [els_p-1:0]      req,
   input  logic [id_width_p-1:0] ptr,
   output logic [els_p-1:0]      grant,
   output logic [id_width_p-1:0] id
);

   int j;

   // Walk the scan order backwards so the earliest requester in priority order is written last.
   always_comb begin
      grant = '0;
      id    = '0;
      j     = 0;
      for (int i = els_p - 1; i >= 0; i--) begin
         j = int'(ptr) + i;
         j = (j >= els_p) ? j - els_p : j;
         if (req[id_width_p'(j)]) begin
            grant                   = '0;
            grant[id_width_p'(j)]   = 1'b1;
            id                      = id_width_p'(j);
         end
      end
   end

endmodule

// File: rtl/bsg_arb_rr_mux_p32_els_p5.sv
// bsg_arb_rr_mux_p32_els_p5: round-robin arbiter feeding a single registered output slot
module bsg_arb_rr_mux_p32_els_p5
   import bsg_arb_rr_mux_p32_els_p5_pkg::*;
#(
   parameter int width_p    = WIDTH_P,
   parameter int els_p      = ELS_P,
   parameter int id_width_p = ID_WIDTH_P
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic [els_p-1:0]         v_i,
   input  logic [els_p*width_p-1:0] data_i,
   input  logic [els_p-1:0]         en_mask_i,
   output logic [els_p-1:0]         ready_o,
   output logic                     v_o,
   output logic [width_p-1:0]       data_o,
   output logic [id_width_p-1:0]    id_o,
   input  logic                     ready_i
);

   logic                  load_en;
   logic                  accept;
   logic [els_p-1:0]      grant;
   logic [id_width_p-1:0] pick_id;
   logic [id_width_p-1:0] p;
   logic [id_width_p-1:0] next_p;
   logic [width_p-1:0]    mux_data;

   bsg_rr_pick_one_hot #(.els_p(els_p), .id_width_p(id_width_p)) pick (
      .req   (v_i & en_mask_i),
      .ptr   (p),
      .grant (grant),
      .id    (pick_id)
   );

   assign load_en = ~v_o | ready_i;
   assign ready_o = (load_en & reset_n_i) ? grant : '0;
   assign accept  = |ready_o;
   assign next_p  = (pick_id == id_width_p'(els_p - 1)) ? '0 : pick_id + 1'b1;

   // One-hot AND-OR select of the granted requester's word.
   always_comb begin
      mux_data = '0;
      for (int k = 0; k < els_p; k++)
         mux_data = mux_data | (data_i[k*width_p +: width_p] & {width_p{ready_o[k]}});
   end

   // Output slot and priority pointer; the pointer only moves past a winner on an accept.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         v_o    <= 1'b0;
         data_o <= '0;
         id_o   <= '0;
         p      <= '0;
      end else if (load_en) begin
         v_o <= accept;
         if (accept) begin
            data_o <= mux_data;
            id_o   <= pick_id;
            p      <= next_p;
         end
      end
   end

endmodule

// File: tb/tb_bsg_arb_rr_mux_p32_els_p5.sv
// tb_bsg_arb_rr_mux_p32_els_p5: directed and randomized checks against a behavioural model
module tb_bsg_arb_rr_mux_p32_els_p5;

   localparam int W = 32;
   localparam int N = 5;

   logic           clk = 0;
   logic           reset_n = 0;
   logic [N-1:0]   v_i = '0;
   logic [N*W-1:0] data_i = '0;
   logic [N-1:0]   en_mask_i = '0;
   logic           ready_i = 0;
   logic [N-1:0]   ready_o;
   logic           v_o;
   logic [W-1:0]   data_o;
   logic [2:0]     id_o;

   int checks = 0;
   int errors = 0;

   // model state
   int           m_p;
   logic         m_v;
   logic [W-1:0] m_data;
   int           m_id;
   int           starve [N];
   logic [N-1:0] acc;

   bsg_arb_rr_mux_p32_els_p5 dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .v_i       (v_i),
      .data_i    (data_i),
      .en_mask_i (en_mask_i),
      .ready_o   (ready_o),
      .v_o       (v_o),
      .data_o    (data_o),
      .id_o      (id_o),
      .ready_i   (ready_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // index the spec's round-robin rule picks this cycle, or -1 for no accept
   function automatic int pick();
      logic [N-1:0] req;
      req = v_i & en_mask_i;
      if (!reset_n || (m_v && !ready_i)) return -1;
      for (int i = 0; i < N; i++)
         if (req[(m_p + i) % N]) return (m_p + i) % N;
      return -1;
   endfunction

   // reference model plus starvation tracking based on the DUT's own grants
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_p = 0; m_v = 0; m_data = '0; m_id = 0;
         for (int k = 0; k < N; k++) starve[k] = 0;
      end else begin
         int k;
         k = pick();
         if (!m_v || ready_i) begin
            m_v = (k >= 0);
            if (k >= 0) begin
               m_data = data_i[k*W +: W];
               m_id   = k;
               m_p    = (k + 1) % N;
            end
         end
         for (int r = 0; r < N; r++) begin
            if (!(v_i[r] & en_mask_i[r]) || ready_o[r]) starve[r] = 0;
            else if (ready_o != 0) begin
               starve[r]++;
               checks++;
               if (starve[r] > N - 1) begin
                  errors++;
                  $display("FAIL starve[%0d]: actual %0d others granted, limit %0d", r, starve[r], N - 1);
               end
            end
         end
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      int k;
      logic [N-1:0] exp_rdy;
      k = pick();
      exp_rdy = (k >= 0) ? N'(1 << k) : '0;
      chk("ready_o", 32'(ready_o), 32'(exp_rdy));
      chk("ready_onehot0", 32'($onehot0(ready_o)), 32'd1);
      chk("v_o", 32'(v_o), 32'(m_v));
      chk("id_o", 32'(id_o), 32'(m_id));
      chk("data_o", data_o, m_data);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 0; v_i = '0; en_mask_i = '0; ready_i = 0; data_i = '0;
      repeat (2) cyc();
      reset_n = 1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // full rotation with everyone requesting
      do_reset();
      for (int k = 0; k < N; k++) data_i[k*W +: W] = 32'h1000 + k;
      v_i = 5'b11111; en_mask_i = 5'b11111; ready_i = 1;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("rot_v", 32'(v_o), 32'd1);
         chk("rot_id", 32'(id_o), i % N);
      end
      // backpressure hold, then resume
      do_reset();
      for (int k = 0; k < N; k++) data_i[k*W +: W] = 32'h2000 + k;
      v_i = 5'b10100; en_mask_i = 5'b11111; ready_i = 0;
      cyc();
      chk("bp_first_id", 32'(id_o), 32'd2);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("bp_hold_id", 32'(id_o), 32'd2);
         chk("bp_hold_v", 32'(v_o), 32'd1);
         chk("bp_ready_o", 32'(ready_o), 32'd0);
      end
      ready_i = 1;
      cyc();
      chk("bp_next_id", 32'(id_o), 32'd4);
      cyc();
      chk("bp_wrap_id", 32'(id_o), 32'd2);
      // single item then drain
      do_reset();
      data_i[0 +: W] = 32'hDEADBEEF;
      v_i = 5'b00001; en_mask_i = 5'b11111; ready_i = 1;
      cyc();
      v_i = '0;
      chk("drain_v1", 32'(v_o), 32'd1);
      chk("drain_data1", data_o, 32'hDEADBEEF);
      cyc();
      chk("drain_v0", 32'(v_o), 32'd0);
      chk("drain_data_held", data_o, 32'hDEADBEEF);
      // masked requesters
      do_reset();
      v_i = 5'b11111; en_mask_i = 5'b01010; ready_i = 1;
      for (int i = 0; i < 6; i++) begin
         chk("mask_ready_o", 32'(ready_o & 5'b10101), 32'd0);
         cyc();
         chk("mask_id", 32'(id_o), (i % 2 == 0) ? 32'd1 : 32'd3);
      end
      // asynchronous reset mid-stream
      do_reset();
      for (int k = 0; k < N; k++) data_i[k*W +: W] = 32'h3000 + k;
      v_i = 5'b11111; en_mask_i = 5'b11111; ready_i = 1;
      repeat (4) cyc();
      chk("arst_pre_id", 32'(id_o), 32'd3);
      #2 reset_n = 0;
      #1;
      chk("arst_v", 32'(v_o), 32'd0);
      chk("arst_data", data_o, 32'd0);
      chk("arst_id", 32'(id_o), 32'd0);
      chk("arst_ready", 32'(ready_o), 32'd0);
      v_i = 5'b01100;
      reset_n = 1;
      cyc();
      chk("arst_first_id", 32'(id_o), 32'd2);
      // randomized traffic
      do_reset();
      en_mask_i = 5'b11111;
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         acc = v_i & ready_o;
         @(posedge clk);
         #1;
         for (int k = 0; k < N; k++) begin
            if (acc[k] || !v_i[k]) begin
               v_i[k] = ($urandom % 3) != 0;
               data_i[k*W +: W] = $urandom;
            end
         end
         if ($urandom % 8 == 0)
            for (int k = 0; k < N; k++) en_mask_i[k] = ($urandom % 4) != 0;
         ready_i = ($urandom % 4) != 0;
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
